// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: pipeline controls and MEM-stage results in, register-file write port and status out.
// master is the upstream/control side; slave is the MEM/WB register.
interface mem_wb_stage_if #(
    parameter int CNT_W = 32
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_regwrite;
    logic              mem_memtoreg;
    logic              mem_link;
    logic [4:0]        mem_rd;
    logic [31:0]       mem_alu_result;
    logic [31:0]       mem_load_data;
    logic [2:0]        mem_load_type;
    logic [31:0]       mem_link_addr;

    logic [4:0]        reg_write;
    logic              regwrite_con;
    logic [31:0]       write_data;
    logic              wb_valid;
    logic              wb_misalign;
    logic [CNT_W-1:0]  wb_retired;

    modport master (
        output stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_link,
               mem_rd, mem_alu_result, mem_load_data, mem_load_type, mem_link_addr,
        input  reg_write, regwrite_con, write_data, wb_valid, wb_misalign, wb_retired
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_link,
               mem_rd, mem_alu_result, mem_load_data, mem_load_type, mem_link_addr,
        output reg_write, regwrite_con, write_data, wb_valid, wb_misalign, wb_retired
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB register with load formatting, misaligned-load write suppression and a retired counter; 1-cycle latency.
// stall holds every output and the counter; flush loads a bubble and wins over stall.
module mem_wb_stage #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_wb_stage_if.slave bus
);

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

    logic [1:0]        offset;
    logic [1:0]        byte_lane;
    logic              half_hi;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_fmt;
    logic [31:0]       data_nxt;
    logic              misalign_nxt;
    logic              regwrite_nxt;

    logic [4:0]        rd_q;
    logic              regwrite_q;
    logic [31:0]       data_q;
    logic              valid_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  retired_q;

    // Lane numbering below is little-endian (lane 0 = bits [7:0]); big-endian mirrors the offset.
    always_comb begin
        offset    = bus.mem_alu_result[1:0];
        byte_lane = BIG_ENDIAN ? ~offset : offset;
        half_hi   = BIG_ENDIAN ? ~offset[1] : offset[1];

        ld_byte = 8'h00;
        case (byte_lane)
            2'd0:    ld_byte = bus.mem_load_data[7:0];
            2'd1:    ld_byte = bus.mem_load_data[15:8];
            2'd2:    ld_byte = bus.mem_load_data[23:16];
            default: ld_byte = bus.mem_load_data[31:24];
        endcase

        ld_half = half_hi ? bus.mem_load_data[31:16] : bus.mem_load_data[15:0];
    end

    always_comb begin
        ld_fmt       = bus.mem_load_data;
        misalign_nxt = 1'b0;
        case (bus.mem_load_type)
            LT_LB:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU: ld_fmt = {24'h000000, ld_byte};
            LT_LH: begin
                ld_fmt       = {{16{ld_half[15]}}, ld_half};
                misalign_nxt = offset[0];
            end
            LT_LHU: begin
                ld_fmt       = {16'h0000, ld_half};
                misalign_nxt = offset[0];
            end
            default: begin
                ld_fmt       = bus.mem_load_data;
                misalign_nxt = (offset != 2'b00);
            end
        endcase
        if (!bus.mem_memtoreg) begin
            misalign_nxt = 1'b0;
        end

        if (bus.mem_link) begin
            data_nxt = bus.mem_link_addr;
        end else if (bus.mem_memtoreg) begin
            data_nxt = ld_fmt;
        end else begin
            data_nxt = bus.mem_alu_result;
        end

        regwrite_nxt = bus.mem_regwrite && (bus.mem_rd != 5'd0) && !misalign_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            data_q     <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else if (bus.flush) begin
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            data_q     <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.mem_valid) begin
                rd_q       <= bus.mem_rd;
                regwrite_q <= regwrite_nxt;
                data_q     <= data_nxt;
                valid_q    <= 1'b1;
                misalign_q <= misalign_nxt;
                if (!misalign_nxt) begin
                    retired_q <= retired_q + CNT_W'(1);
                end
            end else begin
                rd_q       <= 5'd0;
                regwrite_q <= 1'b0;
                data_q     <= 32'h0;
                valid_q    <= 1'b0;
                misalign_q <= 1'b0;
            end
        end
    end

    assign bus.reg_write    = rd_q;
    assign bus.regwrite_con = regwrite_q;
    assign bus.write_data   = data_q;
    assign bus.wb_valid     = valid_q;
    assign bus.wb_misalign  = misalign_q;
    assign bus.wb_retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage (big-endian lanes, 8-bit counter so wrap is reachable).
module tb_mem_wb_stage;

    localparam int CW = 8;
    localparam logic [31:0] D = 32'h8012_34F6;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_ret;

    mem_wb_stage_if #(.CNT_W(CW)) bus ();

    mem_wb_stage #(.BIG_ENDIAN(1'b1), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        link;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [2:0]  lt;
        logic [31:0] link_addr;
        logic [4:0]  e_rd;
        logic        e_rwc;
        logic [31:0] e_data;
        logic        e_valid;
        logic        e_mis;
        logic        e_inc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] rd, input logic rwc,
                             input logic [31:0] data, input logic v, input logic mis,
                             input int ret);
        check({tag, " reg_write"},    32'(bus.reg_write),    32'(rd));
        check({tag, " regwrite_con"}, 32'(bus.regwrite_con), 32'(rwc));
        check({tag, " write_data"},   bus.write_data,        data);
        check({tag, " wb_valid"},     32'(bus.wb_valid),     32'(v));
        check({tag, " wb_misalign"},  32'(bus.wb_misalign),  32'(mis));
        check({tag, " wb_retired"},   32'(bus.wb_retired),   32'(ret[CW-1:0]));
    endtask

    task automatic drive(input vec_t v);
        bus.mem_valid      = v.valid;
        bus.mem_regwrite   = v.regwrite;
        bus.mem_memtoreg   = v.memtoreg;
        bus.mem_link       = v.link;
        bus.mem_rd         = v.rd;
        bus.mem_alu_result = v.alu;
        bus.mem_load_data  = v.ld;
        bus.mem_load_type  = v.lt;
        bus.mem_link_addr  = v.link_addr;
    endtask

    initial begin
        vec_t tmp;
        n_checks = 0;
        n_fail   = 0;
        exp_ret  = 0;

        //             vld rw m2r lnk rd     alu           ld  lt      link_addr       e_rd   rwc e_data          v  mis inc
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,5'd8, 32'h0000_03E8, D, 3'b000, 32'h0,        5'd8,  1'b1,32'h0000_03E8,1'b1,1'b0,1'b1};
        vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,5'd9, 32'h0000_1003, D, 3'b001, 32'h0,        5'd9,  1'b1,32'hFFFF_FFF6,1'b1,1'b0,1'b1};
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,5'd9, 32'h0000_1000, D, 3'b010, 32'h0,        5'd9,  1'b1,32'h0000_0080,1'b1,1'b0,1'b1};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,5'd9, 32'h0000_1000, D, 3'b011, 32'h0,        5'd9,  1'b1,32'hFFFF_8012,1'b1,1'b0,1'b1};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,5'd9, 32'h0000_1002, D, 3'b100, 32'h0,        5'd9,  1'b1,32'h0000_34F6,1'b1,1'b0,1'b1};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,5'd10,32'h0000_03EA, D, 3'b000, 32'h0,        5'd10, 1'b0,32'h8012_34F6,1'b1,1'b1,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,5'd10,32'h0000_03E9, D, 3'b011, 32'h0,        5'd10, 1'b0,32'hFFFF_8012,1'b1,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,5'd10,32'h0000_03E9, D, 3'b001, 32'h0,        5'd10, 1'b1,32'h0000_0012,1'b1,1'b0,1'b1};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,5'd31,32'h0000_1000, D, 3'b000, 32'h0040_0010,5'd31, 1'b1,32'h0040_0010,1'b1,1'b0,1'b1};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0000_0055, D, 3'b000, 32'h0,        5'd0,  1'b0,32'h0000_0055,1'b1,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b1,1'b0,1'b0,5'd5, 32'h0000_0077, D, 3'b000, 32'h0,        5'd0,  1'b0,32'h0000_0000,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,5'd7, 32'h0000_0099, D, 3'b000, 32'h0,        5'd7,  1'b0,32'h0000_0099,1'b1,1'b0,1'b1};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b0,5'd12,32'h0000_1004, D, 3'b111, 32'h0,        5'd12, 1'b1,32'h8012_34F6,1'b1,1'b0,1'b1};
        vecs[13] = '{1'b1,1'b1,1'b1,1'b0,5'd13,32'h0000_1003, D, 3'b100, 32'h0,        5'd13, 1'b0,32'h0000_34F6,1'b1,1'b1,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b0,1'b0,5'd14,32'h0000_03EA, D, 3'b000, 32'h0,        5'd14, 1'b1,32'h0000_03EA,1'b1,1'b0,1'b1};

        rst_n     = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        tmp = vecs[10];
        tmp.valid = 1'b0;
        drive(tmp);
        #3;
        check_all("reset", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            if (vecs[i].e_inc) exp_ret++;
            check_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_rwc, vecs[i].e_data,
                      vecs[i].e_valid, vecs[i].e_mis, exp_ret);
            if (i == 4) check("four loads retired", 32'(bus.wb_retired), 32'd5);
            @(negedge clk);
        end

        // Stall: outputs from vecs[14] must survive changing inputs.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tmp = vecs[i];
            tmp.rd = 5'(20 + i);
            drive(tmp);
            @(posedge clk);
            #1;
            check_all($sformatf("stall%0d", i), 5'd14, 1'b1, 32'h0000_03EA, 1'b1, 1'b0, exp_ret);
            @(negedge clk);
        end

        bus.flush = 1'b1;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check_all("flush+stall", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, exp_ret);
        @(negedge clk);

        bus.stall = 1'b0;
        drive(vecs[7]);
        @(posedge clk);
        #1;
        check_all("flush only", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, exp_ret);
        @(negedge clk);

        bus.flush = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        exp_ret++;
        check_all("after flush", 5'd8, 1'b1, 32'h0000_03E8, 1'b1, 1'b0, exp_ret);

        // Reset between edges, while stalled.
        @(negedge clk);
        bus.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midcycle reset", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        bus.stall = 1'b0;
        exp_ret   = 0;

        // Run the counter to all-ones, then one more retirement wraps it.
        drive(vecs[0]);
        repeat ((1 << CW) - 1) @(posedge clk);
        #1;
        check("counter at max", 32'(bus.wb_retired), 32'h0000_00FF);
        @(posedge clk);
        #1;
        check("counter wrap", 32'(bus.wb_retired), 32'h0000_0000);
        check("wrap entry valid", 32'(bus.wb_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
